// File: rtl/quad_step_decoder_pkg.sv
// Shared phase encoding, direction values and CW-neighbour helper for the quadrature decoder.
package quad_step_decoder_pkg;

  typedef enum logic [1:0] {
    P00 = 2'b00,
    P01 = 2'b01,
    P11 = 2'b11,
    P10 = 2'b10
  } phase_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // CW order: P00 -> P01 -> P11 -> P10 -> P00
  function automatic logic qdec_is_cw(input logic [1:0] old_ph, input logic [1:0] new_ph);
    logic r;
    r = 1'b0;
    case (old_ph)
      P00:     r = (new_ph == P01);
      P01:     r = (new_ph == P11);
      P11:     r = (new_ph == P10);
      P10:     r = (new_ph == P00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_step_decoder_debounce.sv
// qdec_debounce: 1-bit stable-count filter; output follows input after CYCLES stable cycles.
module qdec_debounce
  import quad_step_decoder_pkg::*;
#(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic init_n,
  input  logic load,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!init_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (load) begin
      // Seed straight from the input while the decoder is priming.
      cnt  <= '0;
      dout <= din;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronise, optionally debounce (QDEC_DEBOUNCE_EN), decode Gray phase
// into 1-cycle enable strobes with held direction and a sticky illegal-jump flag.
module quad_step_decoder
  import quad_step_decoder_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int X4_MODE         = 1
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       err_clr,
  output logic       enable,
  output logic       downCounter,
  output logic       err,
  output logic [1:0] ab_state
);

  localparam int NUM_LANES = 2;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("quad_step_decoder: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0][NUM_LANES-1:0] sync_q;
  logic [SYNC_STAGES:0]                  vld_pipe;
  logic [NUM_LANES-1:0]                  filt;
  logic                                  primed;
  phase_t                                ab_q;

  // vld_pipe marks when the synchroniser (and filter seed) holds post-reset pin samples.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {quad_a, quad_b}};
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

`ifdef QDEC_DEBOUNCE_EN
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    qdec_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .init_n (init_n),
      .load   (~vld_pipe[SYNC_STAGES]),
      .din    (sync_q[SYNC_STAGES-1][g]),
      .dout   (filt[g])
    );
  end
`else
  assign filt = sync_q[SYNC_STAGES-1];
`endif

  logic changed, illegal, cw, pulse_cond;
  assign changed    = (filt != ab_q);
  assign illegal    = ((filt ^ ab_q) == 2'b11);
  assign cw         = qdec_is_cw(ab_q, filt);
  assign pulse_cond = (X4_MODE != 0) || (filt == P00);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      ab_q        <= P00;
      primed      <= 1'b0;
      enable      <= 1'b0;
      downCounter <= DIR_UP;
      err         <= 1'b0;
    end else begin
      enable <= 1'b0;
      if (vld_pipe[SYNC_STAGES] && !primed) begin
        ab_q   <= phase_t'(filt);
        primed <= 1'b1;
      end else if (primed && changed) begin
        ab_q <= phase_t'(filt);
        if (!illegal) begin
          downCounter <= cw ? DIR_UP : DIR_DOWN;
          enable      <= pulse_cond;
        end
      end
      // A new illegal jump takes priority over a coincident clear.
      if (primed && changed && illegal) err <= 1'b1;
      else if (err_clr)                 err <= 1'b0;
    end
  end

  assign ab_state = ab_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: X4 and X1 instances side by side, optional debounce build.
module tb_quad_step_decoder;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
`ifdef QDEC_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic clk = 1'b0;
  logic init_n = 1'b0;
  logic quad_a = 1'b0, quad_b = 1'b0, err_clr = 1'b0;
  logic en4, dn4, err4, en0, dn0, err0;
  logic [1:0] ab4, ab0;

  int checks = 0, failures = 0;
  int p4 = 0, p0 = 0, s4, s0;
  logic [11:0] c4 = '0, c0 = '0, sc4, sc0;

  always #5 clk = ~clk;

  quad_step_decoder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .X4_MODE(1)) dut4 (
    .clk(clk), .init_n(init_n), .quad_a(quad_a), .quad_b(quad_b), .err_clr(err_clr),
    .enable(en4), .downCounter(dn4), .err(err4), .ab_state(ab4));

  quad_step_decoder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .X4_MODE(0)) dut0 (
    .clk(clk), .init_n(init_n), .quad_a(quad_a), .quad_b(quad_b), .err_clr(err_clr),
    .enable(en0), .downCounter(dn0), .err(err0), .ab_state(ab0));

  // Model of the downstream 12-bit up/down counter fed by each instance.
  always @(negedge clk) begin
    if (en4) begin p4++; c4 = dn4 ? c4 - 12'd1 : c4 + 12'd1; end
    if (en0) begin p0++; c0 = dn0 ? c0 - 12'd1 : c0 + 12'd1; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic a, input logic b, input int n);
    quad_a = a; quad_b = b;
    repeat (n) tick();
  endtask

  task automatic snap();
    s4 = p4; s0 = p0; sc4 = c4; sc0 = c0;
  endtask

  task automatic do_reset(input logic a, input logic b);
    init_n = 1'b0; quad_a = a; quad_b = b;
    repeat (4) tick();
    init_n = 1'b1;
    repeat (LAT + 4) tick();
  endtask

  task automatic test_reset();
    init_n = 1'b0; quad_a = 1'b1; quad_b = 1'b1;
    repeat (4) tick();
    checks++; if ({en4, dn4, err4, ab4} !== 5'b0) begin failures++;
      $display("FAIL rst_outputs got=%b exp=00000", {en4, dn4, err4, ab4}); end
    checks++; if ({en0, dn0, err0, ab0} !== 5'b0) begin failures++;
      $display("FAIL rst_outputs_x1 got=%b exp=00000", {en0, dn0, err0, ab0}); end
    snap();
    init_n = 1'b1;
    repeat (LAT + 4) tick();
    checks++; if (ab4 !== 2'b11) begin failures++;
      $display("FAIL prime_ab got=%b exp=11", ab4); end
    checks++; if (p4 - s4 !== 0 || p0 - s0 !== 0) begin failures++;
      $display("FAIL prime_no_pulse got=%0d/%0d exp=0/0", p4 - s4, p0 - s0); end
    checks++; if (err4 !== 1'b0) begin failures++;
      $display("FAIL prime_err got=%b exp=0", err4); end
  endtask

  task automatic test_cw_x4();
    do_reset(1'b0, 1'b0);
    snap();
    step(1'b0, 1'b1, LAT - 1);
    checks++; if (en4 !== 1'b0) begin failures++;
      $display("FAIL lat_early got=%b exp=0", en4); end
    tick();
    checks++; if (en4 !== 1'b1 || dn4 !== 1'b0) begin failures++;
      $display("FAIL lat_edge en/dn got=%b%b exp=10", en4, dn4); end
    tick();
    checks++; if (en4 !== 1'b0) begin failures++;
      $display("FAIL one_cycle got=%b exp=0", en4); end
    repeat (20 - LAT - 1) tick();
    step(1'b1, 1'b1, 20);
    step(1'b1, 1'b0, 20);
    step(1'b0, 1'b0, 20);
    checks++; if (p4 - s4 !== 4 || c4 - sc4 !== 12'd4 || dn4 !== 1'b0) begin failures++;
      $display("FAIL cw_x4 pulses=%0d cnt=%h dn=%b exp 4/004/0", p4 - s4, c4 - sc4, dn4); end
    checks++; if (p0 - s0 !== 1 || c0 - sc0 !== 12'd1) begin failures++;
      $display("FAIL cw_x1 pulses=%0d cnt=%h exp 1/001", p0 - s0, c0 - sc0); end
    checks++; if (err4 !== 1'b0) begin failures++;
      $display("FAIL cw_err got=%b exp=0", err4); end
  endtask

  task automatic test_ccw_x1();
    do_reset(1'b0, 1'b0);
    snap();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 20);
      step(1'b1, 1'b1, 20);
      step(1'b0, 1'b1, 20);
      checks++; if (p0 - s0 !== i) begin failures++;
        $display("FAIL ccw_x1_mid%0d got=%0d exp=%0d", i, p0 - s0, i); end
      step(1'b0, 1'b0, 20);
      checks++; if (p0 - s0 !== i + 1) begin failures++;
        $display("FAIL ccw_x1_p00_%0d got=%0d exp=%0d", i, p0 - s0, i + 1); end
    end
    checks++; if (c0 - sc0 !== 12'hFFE || dn0 !== 1'b1) begin failures++;
      $display("FAIL ccw_x1_cnt cnt=%h dn=%b exp FFE/1", c0 - sc0, dn0); end
    checks++; if (p4 - s4 !== 8 || c4 - sc4 !== 12'hFF8 || dn4 !== 1'b1) begin failures++;
      $display("FAIL ccw_x4 pulses=%0d cnt=%h dn=%b exp 8/FF8/1", p4 - s4, c4 - sc4, dn4); end
  endtask

  task automatic test_err();
    snap();
    step(1'b1, 1'b1, 20);
    checks++; if (err4 !== 1'b1 || err0 !== 1'b1 || ab4 !== 2'b11) begin failures++;
      $display("FAIL err_set err=%b%b ab=%b exp 11/11", err4, err0, ab4); end
    checks++; if (p4 - s4 !== 0) begin failures++;
      $display("FAIL err_no_pulse got=%0d exp=0", p4 - s4); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err4 !== 1'b0) begin failures++;
      $display("FAIL err_clr got=%b exp=0", err4); end
    step(1'b0, 1'b1, 20);
    checks++; if (err4 !== 1'b0 || p4 - s4 !== 1 || dn4 !== 1'b1) begin failures++;
      $display("FAIL err_legal err=%b pulses=%0d dn=%b exp 0/1/1", err4, p4 - s4, dn4); end
    quad_a = 1'b1; quad_b = 1'b0;
    repeat (LAT - 1) tick();
    checks++; if (err4 !== 1'b0) begin failures++;
      $display("FAIL err_pre_jump got=%b exp=0", err4); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err4 !== 1'b1 || en4 !== 1'b0) begin failures++;
      $display("FAIL err_set_wins err=%b en=%b exp 1/0", err4, en4); end
    repeat (20) tick();
    checks++; if (ab4 !== 2'b10) begin failures++;
      $display("FAIL err_ab got=%b exp=10", ab4); end
  endtask

`ifdef QDEC_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset(1'b0, 1'b0);
    snap();
    step(1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 20);
    checks++; if (ab4 !== 2'b00 || p4 - s4 !== 0) begin failures++;
      $display("FAIL glitch ab=%b pulses=%0d exp 00/0", ab4, p4 - s4); end
    // 00 -> 10 is the CCW neighbour.
    step(1'b1, 1'b0, LAT - 1);
    checks++; if (en4 !== 1'b0) begin failures++;
      $display("FAIL deb_lat_early got=%b exp=0", en4); end
    tick();
    checks++; if (en4 !== 1'b1 || dn4 !== 1'b1) begin failures++;
      $display("FAIL deb_lat_edge en/dn got=%b%b exp=11", en4, dn4); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b0);
    step(1'b1, 1'b0, 20);
    step(1'b1, 1'b1, 20);
    checks++; if (ab4 !== 2'b11 || dn4 !== 1'b1) begin failures++;
      $display("FAIL mid_pre ab=%b dn=%b exp 11/1", ab4, dn4); end
    init_n = 1'b0; tick();
    checks++; if ({en4, dn4, err4, ab4, en0, dn0, err0, ab0} !== 10'b0) begin failures++;
      $display("FAIL mid_rst got=%b exp=0", {en4, dn4, err4, ab4, en0, dn0, err0, ab0}); end
    repeat (3) tick();
    snap();
    init_n = 1'b1;
    repeat (LAT + 6) tick();
    checks++; if (ab4 !== 2'b11 || p4 - s4 !== 0 || err4 !== 1'b0) begin failures++;
      $display("FAIL mid_reprime ab=%b pulses=%0d err=%b exp 11/0/0", ab4, p4 - s4, err4); end
    step(1'b0, 1'b1, 20);
    checks++; if (p4 - s4 !== 1 || dn4 !== 1'b1) begin failures++;
      $display("FAIL mid_first_step pulses=%0d dn=%b exp 1/1", p4 - s4, dn4); end
  endtask

  initial begin
    test_reset();
    test_cw_x4();
    test_ccw_x1();
    test_err();
`ifdef QDEC_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
